sd_data_transmit_shift_register: RTL and testbench

//  Write-path partner of the SD data receive shifter, driven by the same data FSM.

---
 rtl/sd_data_transmit_shift_register_pkg.sv | 31 +++
 rtl/sd_data_transmit_shift_register_if.sv | 32 +++
 rtl/sd_data_transmit_shift_register_crc16_line.sv | 36 +++
 rtl/sd_data_transmit_shift_register.sv | 114 +++++++++++
 tb/tb_sd_data_transmit_shift_register.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/sd_data_transmit_shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sd_data_transmit_shift_register_pkg
// Brief   : Shared data-FSM state encodings and CRC16 constants for SD data path
// Rev     : 1.0 - initial release
// ============================================================================
package sd_data_transmit_shift_register_pkg;

  localparam int CRC_W  = 16;
  localparam int WORD_W = 32;
  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

  typedef enum logic [3:0] {
    DATA_STATE_IDLE              = 4'd0,
    DATA_STATE_SEND_START_BIT    = 4'd1,
    DATA_STATE_SEND              = 4'd2,
    DATA_STATE_SEND_CRC          = 4'd3,
    DATA_STATE_SEND_END_BIT      = 4'd4,
    DATA_STATE_WAIT_BUSY         = 4'd5,
    DATA_STATE_RECEIVE_START_BIT = 4'd6,
    DATA_STATE_RECEIVE           = 4'd7,
    DATA_STATE_RECEIVE_CRC       = 4'd8,
    DATA_STATE_RECEIVE_END_BIT   = 4'd9
  } data_state_e;

  function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_data_transmit_shift_register_if.sv
`default_nettype none
// ============================================================================
// Module  : sd_data_transmit_shift_register_if
// Brief   : Data-FSM / tx-FIFO / pad-side bundle of the SD transmit shifter
// Rev     : 1.0 - initial release
// ============================================================================
interface sd_data_transmit_shift_register_if;
  import sd_data_transmit_shift_register_pkg::*;

  logic [3:0]        in_current_state;
  logic              in_data_width;
  logic [13:0]       in_has_send_bit;
  logic [11:0]       in_block_len;
  logic [WORD_W-1:0] sd_fifo_rdata;
  logic              sd_fifo_re;
  logic [3:0]        out_serial_data;
  logic [3:0]        out_data_oe;

  modport master (
    output in_current_state, in_data_width, in_has_send_bit, in_block_len,
    output sd_fifo_rdata,
    input  sd_fifo_re, out_serial_data, out_data_oe
  );

  modport slave (
    input  in_current_state, in_data_width, in_has_send_bit, in_block_len,
    input  sd_fifo_rdata,
    output sd_fifo_re, out_serial_data, out_data_oe
  );

endinterface
`default_nettype wire

// File: rtl/sd_data_transmit_shift_register_crc16_line.sv
`default_nettype none
// ============================================================================
// Module  : sd_crc16_line
// Brief   : One serial CRC16 (x^16+x^12+x^5+1) lane with clear/update/shift-out
// Rev     : 1.0 - initial release
// ============================================================================
module sd_crc16_line
  import sd_data_transmit_shift_register_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  input  wire logic i_shift,
  input  wire logic i_din,
  output logic      o_msb
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = r_crc[CRC_W-1] ^ i_din;
  assign o_msb = r_crc[CRC_W-1];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC16_POLY : '0);
    end else if (i_shift) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_data_transmit_shift_register.sv
`default_nettype none
// ============================================================================
// Module  : sd_data_transmit_shift_register
// Brief   : Serialises tx-FIFO words onto DAT[0] or DAT[3:0] with per-line CRC16.
//           Build option SD_TX_BYTE_SWAP_EN sends byte 0 of each FIFO word first.
// Rev     : 1.0 - initial release
// ============================================================================
module sd_data_transmit_shift_register
  import sd_data_transmit_shift_register_pkg::*;
(
  input  wire logic                                in_sd_clk,
  input  wire logic                                hrst,
  input  wire logic                                in_soft_reset,
  sd_data_transmit_shift_register_if.slave         bus
);

  logic              w_rst;
  logic              w_wide;
  logic              w_st_start;
  logic              w_st_send;
  logic              w_st_crc;
  logic              w_st_end;
  logic [13:0]       w_last;
  logic              w_boundary;
  logic              w_pop;
  logic [WORD_W-1:0] w_load_word;
  logic [3:0]        w_din;
  logic [3:0]        w_crc_msb;
  logic [3:0]        w_ser;
  logic [3:0]        w_oe;

  logic [WORD_W-1:0] r_shift;
  logic [3:0]        r_ser;
  logic [3:0]        r_oe;

  assign w_rst      = hrst | ~in_soft_reset;
  assign w_wide     = bus.in_data_width;
  assign w_st_start = (bus.in_current_state == DATA_STATE_SEND_START_BIT);
  assign w_st_send  = (bus.in_current_state == DATA_STATE_SEND);
  assign w_st_crc   = (bus.in_current_state == DATA_STATE_SEND_CRC);
  assign w_st_end   = (bus.in_current_state == DATA_STATE_SEND_END_BIT);

  // 2048 bytes in 1-bit mode wraps to 0 before the decrement, giving 16383.
  assign w_last = w_wide ? ({1'b0, bus.in_block_len, 1'b0} - 14'd1)
                         : ({bus.in_block_len[10:0], 3'b000} - 14'd1);

  assign w_boundary = w_wide ? (bus.in_has_send_bit[2:0] == 3'h7)
                             : (bus.in_has_send_bit[4:0] == 5'h1F);
  assign w_pop      = w_st_start | (w_st_send & w_boundary & (bus.in_has_send_bit != w_last));
  assign bus.sd_fifo_re = w_pop & ~w_rst;

`ifdef SD_TX_BYTE_SWAP_EN
  assign w_load_word = byte_swap(bus.sd_fifo_rdata);
`else
  assign w_load_word = bus.sd_fifo_rdata;
`endif

  always_ff @(posedge in_sd_clk) begin
    if (w_rst) begin
      r_shift <= '0;
    end else if (w_pop) begin
      r_shift <= w_load_word;
    end else if (w_st_send) begin
      r_shift <= w_wide ? {r_shift[WORD_W-5:0], 4'h0} : {r_shift[WORD_W-2:0], 1'b0};
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_crc_lane
      logic w_lane_on;
      assign w_lane_on = w_wide || (i == 0);
      assign w_din[i]  = w_wide ? r_shift[WORD_W-4+i] : r_shift[WORD_W-1];

      sd_crc16_line u_crc (
        .clk     (in_sd_clk),
        .rst     (w_rst),
        .i_clr   (w_st_start),
        .i_en    (w_st_send & w_lane_on),
        .i_shift (w_st_crc & w_lane_on),
        .i_din   (w_din[i]),
        .o_msb   (w_crc_msb[i])
      );
    end
  endgenerate

  always_comb begin
    w_ser = 4'hF;
    w_oe  = 4'h0;
    if (w_st_send) begin
      w_ser = w_wide ? r_shift[WORD_W-1:WORD_W-4] : {3'b111, r_shift[WORD_W-1]};
      w_oe  = w_wide ? 4'hF : 4'h1;
    end else if (w_st_crc) begin
      w_ser = w_wide ? w_crc_msb : {3'b111, w_crc_msb[0]};
      w_oe  = w_wide ? 4'hF : 4'h1;
    end else if (w_st_end) begin
      w_oe  = w_wide ? 4'hF : 4'h1;
    end
  end

  always_ff @(posedge in_sd_clk) begin
    if (w_rst) begin
      r_ser <= 4'hF;
      r_oe  <= 4'h0;
    end else begin
      r_ser <= w_ser;
      r_oe  <= w_oe;
    end
  end

  assign bus.out_serial_data = r_ser;
  assign bus.out_data_oe     = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_sd_data_transmit_shift_register.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_data_transmit_shift_register
// Brief   : Self-checking bench: bench plays the data FSM and tx FIFO, compares
//           every cycle against a bit-stream/CRC reference model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_sd_data_transmit_shift_register;
  import sd_data_transmit_shift_register_pkg::*;

  logic clk = 1'b0;
  logic hrst = 1'b1;
  logic soft_n = 1'b1;
  always #5 clk = ~clk;

  sd_data_transmit_shift_register_if bus ();

  sd_data_transmit_shift_register dut (
    .in_sd_clk     (clk),
    .hrst          (hrst),
    .in_soft_reset (soft_n),
    .bus           (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [31:0] fifo_q[$];
  logic [15:0] cap_crc0;
  logic [31:0] cap_send;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef SD_TX_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // One FSM cycle: pop strobe is checked inside the cycle, registered outputs after the edge.
  task automatic cycle(input logic [3:0] st, input int has, input logic exp_re,
                       input logic [3:0] exp_ser, input logic [3:0] exp_oe, input string tag);
    bus.in_current_state = st;
    bus.in_has_send_bit  = has[13:0];
    bus.sd_fifo_rdata    = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    #1;
    check({tag, "_re"}, {31'b0, bus.sd_fifo_re}, {31'b0, exp_re});
    if (bus.sd_fifo_re === 1'b1) begin
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    @(posedge clk);
    #1;
    check({tag, "_ser"}, {28'b0, bus.out_serial_data}, {28'b0, exp_ser});
    check({tag, "_oe"},  {28'b0, bus.out_data_oe},     {28'b0, exp_oe});
  endtask

  task automatic run_block(input logic w4, input int blen, input int abort_at);
    logic [31:0] words[$];
    logic [15:0] crc[4];
    logic [31:0] w;
    logic [3:0]  ser;
    logic [3:0]  oe;
    int          last;
    int          bpw;
    words = fifo_q;
    for (int i = 0; i < 4; i++) crc[i] = 16'h0;
    bus.in_data_width = w4;
    bus.in_block_len  = blen[11:0];
    last = w4 ? blen * 2 - 1 : blen * 8 - 1;
    bpw  = w4 ? 8 : 32;
    oe   = w4 ? 4'hF : 4'h1;
    cycle(DATA_STATE_SEND_START_BIT, 0, 1'b1, 4'hF, 4'h0, "start");
    for (int k = 0; k <= last; k++) begin
      w = model_word(words[k / bpw]);
      if (w4) begin
        ser = w[31 - 4 * (k % bpw) -: 4];
        for (int i = 0; i < 4; i++) crc[i] = crc_step(crc[i], ser[i]);
        if (k < 8) cap_send[31 - 4 * k -: 4] = ser;
      end else begin
        ser = {3'b111, w[31 - (k % bpw)]};
        crc[0] = crc_step(crc[0], ser[0]);
        if (k < 32) cap_send[31 - k] = ser[0];
      end
      if (k == abort_at) begin
        hrst = 1'b1;
        cycle(DATA_STATE_SEND, k, 1'b0, 4'hF, 4'h0, "abort");
        hrst = 1'b0;
        fifo_q.delete();
        cycle(DATA_STATE_IDLE, 0, 1'b0, 4'hF, 4'h0, "post_abort");
        return;
      end
      cycle(DATA_STATE_SEND, k, ((k % bpw) == bpw - 1) && (k != last), ser, oe, "send");
    end
    for (int j = 0; j < 16; j++) begin
      ser = w4 ? {crc[3][15 - j], crc[2][15 - j], crc[1][15 - j], crc[0][15 - j]}
               : {3'b111, crc[0][15 - j]};
      cycle(DATA_STATE_SEND_CRC, last, 1'b0, ser, oe, "crc");
      cap_crc0[15 - j] = bus.out_serial_data[0];
    end
    cycle(DATA_STATE_SEND_END_BIT, last, 1'b0, 4'hF, oe, "end");
    cycle(DATA_STATE_IDLE, 0, 1'b0, 4'hF, 4'h0, "idle");
    check("fifo_drained", fifo_q.size(), 32'd0);
  endtask

  initial begin
    bus.in_current_state = DATA_STATE_IDLE;
    bus.in_data_width    = 1'b1;
    bus.in_has_send_bit  = '0;
    bus.in_block_len     = 12'd4;
    bus.sd_fifo_rdata    = '0;
    @(posedge clk);
    #1;

    // Hard reset, then soft reset, while the FSM sits in states that would drive the bus.
    cycle(DATA_STATE_SEND_START_BIT, 0, 1'b0, 4'hF, 4'h0, "hrst_a");
    cycle(DATA_STATE_SEND, 0, 1'b0, 4'hF, 4'h0, "hrst_b");
    hrst   = 1'b0;
    soft_n = 1'b0;
    cycle(DATA_STATE_SEND_START_BIT, 0, 1'b0, 4'hF, 4'h0, "srst_a");
    cycle(DATA_STATE_SEND, 0, 1'b0, 4'hF, 4'h0, "srst_b");
    soft_n = 1'b1;
    cycle(DATA_STATE_IDLE, 0, 1'b0, 4'hF, 4'h0, "idle0");

    pops = 0;
    repeat (128) fifo_q.push_back(32'h0);
    run_block(1'b0, 512, -1);
    check("zero_pops", pops, 32'd128);

    repeat (128) fifo_q.push_back(32'hFFFF_FFFF);
    run_block(1'b0, 512, -1);
    check("ff_crc", {16'h0, cap_crc0}, 32'h0000_7FA1);

    fifo_q.push_back(32'h1234_5678);
    run_block(1'b1, 4, -1);
`ifdef SD_TX_BYTE_SWAP_EN
    check("nibbles", cap_send, 32'h7856_3412);
`else
    check("nibbles", cap_send, 32'h1234_5678);
`endif

    for (int t = 0; t < 6; t++) begin
      logic w4;
      int   blen;
      w4   = 1'($urandom_range(0, 1));
      blen = 4 * $urandom_range(1, 32);
      for (int n = 0; n < blen / 4; n++) fifo_q.push_back($urandom);
      run_block(w4, blen, -1);
    end

    for (int n = 0; n < 64; n++) fifo_q.push_back($urandom);
    run_block(1'b0, 256, 100);
    for (int n = 0; n < 16; n++) fifo_q.push_back($urandom);
    run_block(1'b0, 64, -1);
    for (int n = 0; n < 16; n++) fifo_q.push_back($urandom);
    run_block(1'b1, 64, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
